// File: rtl/or_pkg.sv
// Shared constants and elaboration helpers for the OR-reduction blocks.
package or_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Node count at tree level k when each level pairs up its inputs
    function automatic int lvl_width(input int w, input int k);
        int n;
        n = w;
        for (int i = 0; i < k; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    function automatic int lvl_off(input int w, input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) begin
            o += lvl_width(w, i);
        end
        return o;
    endfunction

endpackage

// File: rtl/or_tree.sv
// Balanced binary tree of 2-input ORs; an odd leftover at any level passes through.
module or_tree
    import or_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    output logic             out
);

    localparam int DEPTH = $clog2(WIDTH);
    localparam int TOTAL = lvl_off(WIDTH, DEPTH + 1);

    // All levels packed end to end; level k starts at lvl_off(WIDTH, k)
    logic [TOTAL-1:0] node;

    assign node[WIDTH-1:0] = in;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_lvl
        localparam int P  = lvl_width(WIDTH, k - 1);
        localparam int N  = lvl_width(WIDTH, k);
        localparam int PO = lvl_off(WIDTH, k - 1);
        localparam int NO = lvl_off(WIDTH, k);
        for (genvar j = 0; j < P / 2; j++) begin : g_pair
            assign node[NO+j] = node[PO+2*j] | node[PO+2*j+1];
        end
        if (P % 2 == 1) begin : g_pass
            assign node[NO+N-1] = node[PO+P-1];
        end
    end

    assign out = node[TOTAL-1];

endmodule

// File: rtl/or8_way.sv
// Or8Way reduction gate with registered copy, sticky flag and rising-edge pulse.
module or8_way
    import or_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             clr,
    output logic             out,
    output logic             out_q,
    output logic             sticky,
    output logic             rise
);

    or_tree #(
        .WIDTH(WIDTH)
    ) u_tree (
        .in (in),
        .out(out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= 1'b0;
            sticky <= 1'b0;
            rise   <= 1'b0;
        end else begin
            out_q  <= out;
            rise   <= out & ~out_q;
            // clear beats a simultaneous set
            sticky <= clr ? 1'b0 : (sticky | out);
        end
    end

endmodule

// File: tb/tb_or8_way.sv
// Directed-vector bench for or8_way.
`timescale 1ns/1ps
module tb_or8_way;

    logic       clk;
    logic       rst;
    logic [7:0] in;
    logic       clr;
    logic       out;
    logic       out_q;
    logic       sticky;
    logic       rise;

    int vectors;
    int miscompares;

    or8_way #(
        .WIDTH(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .clr   (clr),
        .out   (out),
        .out_q (out_q),
        .sticky(sticky),
        .rise  (rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in  = 8'h00;
        clr = 1'b0;
        tick();
        vectors++;
        if (out_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_q got=%b exp=0", out_q);
        end
        vectors++;
        if (sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sticky got=%b exp=0", sticky);
        end
        vectors++;
        if (rise !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rise got=%b exp=0", rise);
        end
        vectors++;
        if (out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out got=%b exp=0", out);
        end
        rst = 1'b0;
    endtask

    task automatic test_comb();
        logic [7:0] pat [6];
        logic       exp [6];
        pat = '{8'b00000000, 8'b00000001, 8'b00010000,
                8'b00000010, 8'b10000000, 8'b00110001};
        exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            in = pat[i];
            #1;
            vectors++;
            if (out !== exp[i]) begin
                miscompares++;
                $display("FAIL comb_out in=%b got=%b exp=%b", pat[i], out, exp[i]);
            end
        end
        in = 8'b11111111;
        #1;
        vectors++;
        if (out !== 1'b1) begin
            miscompares++;
            $display("FAIL comb_all_ones got=%b exp=1", out);
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 256; v++) begin
            in = v[7:0];
            #1;
            vectors++;
            if (out !== (v != 0)) begin
                miscompares++;
                $display("FAIL sweep in=%h got=%b exp=%b", v[7:0], out, (v != 0));
            end
        end
    endtask

    task automatic test_pulse();
        in  = 8'h00;
        clr = 1'b0;
        tick();
        vectors++;
        if (out_q !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_idle_out_q got=%b exp=0", out_q);
        end
        in = 8'h01;
        tick();
        vectors++;
        if ({out_q, rise, sticky} !== 3'b111) begin
            miscompares++;
            $display("FAIL pulse_first q/rise/sticky got=%b exp=111", {out_q, rise, sticky});
        end
        tick();
        vectors++;
        if ({out_q, rise, sticky} !== 3'b101) begin
            miscompares++;
            $display("FAIL pulse_held q/rise/sticky got=%b exp=101", {out_q, rise, sticky});
        end
    endtask

    task automatic test_clr();
        in  = 8'h00;
        clr = 1'b1;
        tick();
        vectors++;
        if (sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_idle sticky got=%b exp=0", sticky);
        end
        in = 8'h80;
        tick();
        vectors++;
        if ({sticky, rise} !== 2'b01) begin
            miscompares++;
            $display("FAIL clr_wins sticky/rise got=%b exp=01", {sticky, rise});
        end
        clr = 1'b0;
        tick();
        vectors++;
        if ({sticky, rise, out_q} !== 3'b101) begin
            miscompares++;
            $display("FAIL clr_release sticky/rise/q got=%b exp=101", {sticky, rise, out_q});
        end
    endtask

    task automatic test_async_rst();
        in = 8'h80;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_q, sticky, rise} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_rst q/sticky/rise got=%b exp=000", {out_q, sticky, rise});
        end
        vectors++;
        if (out !== 1'b1) begin
            miscompares++;
            $display("FAIL async_rst_out got=%b exp=1", out);
        end
        in = 8'h00;
        #1;
        vectors++;
        if (out !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_track_zero got=%b exp=0", out);
        end
        in = 8'h04;
        #1;
        vectors++;
        if (out !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_track_one got=%b exp=1", out);
        end
        tick();
        vectors++;
        if ({out_q, sticky, rise} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_held q/sticky/rise got=%b exp=000", {out_q, sticky, rise});
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({out_q, rise, sticky} !== 3'b111) begin
            miscompares++;
            $display("FAIL rst_release q/rise/sticky got=%b exp=111", {out_q, rise, sticky});
        end
        tick();
        vectors++;
        if (rise !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_release_rise_drop got=%b exp=0", rise);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        in  = 8'h00;
        clr = 1'b0;
        test_reset();
        test_comb();
        test_sweep();
        test_pulse();
        test_clr();
        test_async_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
